// File: rtl/enemy_wave_scheduler.sv
// Spawn/wave sequencer for a bank of NUM_SLOTS enemies. The spawn word port is rand_word because
// 'rand' is a reserved word in SystemVerilog. Define SCHED_PAUSE_EN to add the pause input.

module ews_slot_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic alive,
  input  logic coll,
  output logic kill,
  output logic hit
);
  logic alive_q, alive_d, coll_q, coll_d;

  always_comb begin
    alive_d = alive;
    coll_d  = coll;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      alive_q <= alive_d;
      coll_q  <= coll_d;
    end
  end

  // A fall while the collision flag is up is a death by collision, not a kill.
  assign kill = alive_q & ~alive & ~coll;
  assign hit  = coll & ~coll_q;
endmodule

module enemy_wave_scheduler #(
  parameter int          NUM_SLOTS      = 4,
  parameter int          BASE_INTERVAL  = 50_000_000,
  parameter int          INTERVAL_STEP  = 5_000_000,
  parameter int          MIN_INTERVAL   = 10_000_000,
  parameter int          KILLS_PER_WAVE = 8,
  parameter int          START_LIVES    = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef SCHED_PAUSE_EN
  input  logic                 pause,
`endif
  input  logic [NUM_SLOTS-1:0] alive_vec,
  input  logic [NUM_SLOTS-1:0] collision_vec,
  output logic [NUM_SLOTS-1:0] spawn_vec,
  output logic [5:0]           rand_word,
  output logic                 enable,
  output logic [1:0]           lives,
  output logic [9:0]           kills,
  output logic [3:0]           wave,
  output logic                 game_over
);
  localparam int          SW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [26:0] BASE_I = 27'(BASE_INTERVAL);
  localparam logic [26:0] STEP_I = 27'(INTERVAL_STEP);
  localparam logic [26:0] MIN_I  = 27'(MIN_INTERVAL);
  localparam logic [26:0] INIT_I = (BASE_INTERVAL < MIN_INTERVAL) ? MIN_I : BASE_I;
  localparam logic [9:0]  KPW_M1 = 10'(KILLS_PER_WAVE - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SPAWN, S_ACK, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [26:0]     timer_q, timer_d, interval_q, interval_d;
  logic [SW-1:0]   ptr_q, ptr_d, slot_q, slot_d, sel;
  logic [1:0]      ack_q, ack_d, lives_q, lives_d;
  logic [5:0]      rand_q, rand_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [9:0]      kills_q, kills_d, wk_q, wk_d;
  logic [3:0]      wave_q, wave_d;
  logic            start_q, start_d;
  logic            start_rise, counting, paused, free_found;
  logic [26:0]     lim, step_total, raw;
  logic [NUM_SLOTS-1:0] kill_v, hit_v;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    ews_slot_edge u_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .alive(alive_vec[g]),
      .coll (collision_vec[g]),
      .kill (kill_v[g]),
      .hit  (hit_v[g])
    );
  end

  assign counting   = (state_q == S_RUN) || (state_q == S_SPAWN) || (state_q == S_ACK);
  assign start_rise = start & ~start_q;
  assign lim        = interval_q - 27'd1;

`ifdef SCHED_PAUSE_EN
  assign paused = pause && ((state_q == S_RUN) || (state_q == S_ACK));
`else
  assign paused = 1'b0;
`endif

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Interval is derived from the registered wave, so it lags a wave change by one cycle.
  always_comb begin
    step_total = 27'(wave_q) * STEP_I;
    raw        = (BASE_I > step_total) ? (BASE_I - step_total) : 27'd0;
    interval_d = (raw < MIN_I) ? MIN_I : raw;
  end

  // First free slot at or after the round-robin pointer.
  always_comb begin : p_sel
    int idx;
    free_found = 1'b0;
    sel        = '0;
    idx        = 0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
      if (!free_found && !alive_vec[SW'(idx)]) begin
        free_found = 1'b1;
        sel        = SW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    ack_d   = ack_q;
    rand_d  = rand_q;
    lfsr_d  = lfsr_q;
    lives_d = lives_q;
    kills_d = kills_q;
    wave_d  = wave_q;
    wk_d    = wk_q;
    start_d = start;

    if (!counting || (state_q == S_RUN && !paused)) lfsr_d = lfsr_step(lfsr_q);
    // Timer runs through SPAWN/ACK too, so the spawn-to-spawn period equals the interval.
    if (counting && !paused && timer_q < lim) timer_d = timer_q + 27'd1;

    if (counting) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (kill_v[i]) begin
          if (kills_d != 10'h3FF) kills_d = kills_d + 10'd1;
          if (wk_d >= KPW_M1) begin
            wk_d = 10'd0;
            if (wave_d != 4'hF) wave_d = wave_d + 4'd1;
          end else begin
            wk_d = wk_d + 10'd1;
          end
        end
        if (hit_v[i] && lives_d != 2'd0) lives_d = lives_d - 2'd1;
      end
    end

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          state_d = S_RUN;
          lives_d = 2'(START_LIVES);
          kills_d = 10'd0;
          wave_d  = 4'd0;
          wk_d    = 10'd0;
          timer_d = 27'd0;
        end
      end
      S_RUN: begin
        if (!paused && timer_q >= lim && free_found) begin
          state_d = S_SPAWN;
          slot_d  = sel;
          rand_d  = lfsr_q[5:0];
          timer_d = 27'd0;
        end
      end
      S_SPAWN: begin
        state_d = S_ACK;
        ack_d   = 2'd0;
        ptr_d   = (int'(slot_q) == NUM_SLOTS - 1) ? '0 : slot_q + SW'(1);
      end
      S_ACK: begin
        if (alive_vec[slot_q] || (!paused && ack_q == 2'd3)) state_d = S_RUN;
        else if (!paused) ack_d = ack_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Losing the last life overrides whatever spawn was in flight.
    if (counting && lives_q != 2'd0 && lives_d == 2'd0) state_d = S_OVER;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= 27'd0;
      interval_q <= INIT_I;
      ptr_q      <= '0;
      slot_q     <= '0;
      ack_q      <= 2'd0;
      rand_q     <= LFSR_SEED[5:0];
      lfsr_q     <= LFSR_SEED;
      lives_q    <= 2'(START_LIVES);
      kills_q    <= 10'd0;
      wave_q     <= 4'd0;
      wk_q       <= 10'd0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      interval_q <= interval_d;
      ptr_q      <= ptr_d;
      slot_q     <= slot_d;
      ack_q      <= ack_d;
      rand_q     <= rand_d;
      lfsr_q     <= lfsr_d;
      lives_q    <= lives_d;
      kills_q    <= kills_d;
      wave_q     <= wave_d;
      wk_q       <= wk_d;
      start_q    <= start_d;
    end
  end

  always_comb begin
    spawn_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      spawn_vec[i] = (state_q == S_SPAWN) && (slot_q == SW'(i));
  end

  assign rand_word = rand_q;
  assign enable    = counting && !paused;
  assign lives     = lives_q;
  assign kills     = kills_q;
  assign wave      = wave_q;
  assign game_over = (state_q == S_OVER);
endmodule
